// File: rtl/distance_filter.sv
// Ultrasonic range conditioner: rejects out-of-range echoes, averages the last
// 2**DEPTH_LOG2 accepted samples and flags steady and lost-target conditions.
module distance_filter #(
    parameter int unsigned DEPTH_LOG2 = 2,
    parameter logic [16:0] MAX_DIST   = 17'd100000,
    parameter logic [16:0] STABLE_TOL = 17'd50,
    parameter int unsigned STABLE_CNT = 8,
    parameter int unsigned MISS_LIMIT = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_i,
    input  logic [16:0] distance_i,
    input  logic        flush_i,
    output logic [16:0] dist_o,
    output logic        dist_valid_o,
    output logic        stable_o,
    output logic [7:0]  stable_cnt_o,
    output logic        lost_o
);

    localparam int unsigned DW     = 17;
    localparam int unsigned DEPTH  = 1 << DEPTH_LOG2;
    localparam int unsigned SUM_W  = DW + DEPTH_LOG2;
    localparam int unsigned FILL_W = DEPTH_LOG2 + 1;
    localparam int unsigned CNT_W  = 8;

    logic [DW-1:0]         win [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [FILL_W-1:0]     fill_cnt;
    logic [SUM_W-1:0]      sum;
    logic [CNT_W-1:0]      miss_cnt;

    logic              accept_c;
    logic              reject_c;
    logic              full_c;
    logic              emit_c;
    logic [SUM_W-1:0]  sum_next_c;
    logic [DW-1:0]     avg_c;
    logic [DW-1:0]     diff_c;
    logic [CNT_W-1:0]  stable_cnt_next_c;
    logic [CNT_W-1:0]  miss_next_c;

    // Sample classification, running-sum update and steadiness evaluation
    always_comb begin
        accept_c = valid_i && !flush_i && (distance_i != '0) && (distance_i <= MAX_DIST);
        reject_c = valid_i && !flush_i && !accept_c;
        full_c   = (fill_cnt == FILL_W'(DEPTH));
        emit_c   = accept_c && (full_c || (fill_cnt == FILL_W'(DEPTH - 1)));

        if (full_c) begin
            sum_next_c = sum - SUM_W'(win[wr_ptr]) + SUM_W'(distance_i);
        end else begin
            sum_next_c = sum + SUM_W'(distance_i);
        end
        avg_c = DW'(sum_next_c >> DEPTH_LOG2);

        if (avg_c >= dist_o) begin
            diff_c = avg_c - dist_o;
        end else begin
            diff_c = dist_o - avg_c;
        end

        // The first average after a (re)fill has no valid predecessor
        stable_cnt_next_c = '0;
        if (full_c && (diff_c <= STABLE_TOL)) begin
            if (stable_cnt_o == CNT_W'(STABLE_CNT)) begin
                stable_cnt_next_c = stable_cnt_o;
            end else begin
                stable_cnt_next_c = stable_cnt_o + CNT_W'(1);
            end
        end

        if (miss_cnt == CNT_W'(MISS_LIMIT)) begin
            miss_next_c = miss_cnt;
        end else begin
            miss_next_c = miss_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                win[i] <= '0;
            end
            wr_ptr       <= '0;
            fill_cnt     <= '0;
            sum          <= '0;
            miss_cnt     <= '0;
            dist_o       <= '0;
            dist_valid_o <= 1'b0;
            stable_o     <= 1'b0;
            stable_cnt_o <= '0;
            lost_o       <= 1'b0;
        end else begin
            dist_valid_o <= 1'b0;
            if (flush_i) begin
                wr_ptr       <= '0;
                fill_cnt     <= '0;
                sum          <= '0;
                miss_cnt     <= '0;
                stable_cnt_o <= '0;
                stable_o     <= 1'b0;
            end else if (accept_c) begin
                win[wr_ptr] <= distance_i;
                wr_ptr      <= wr_ptr + 1'b1;
                sum         <= sum_next_c;
                miss_cnt    <= '0;
                lost_o      <= 1'b0;
                if (!full_c) begin
                    fill_cnt <= fill_cnt + 1'b1;
                end
                if (emit_c) begin
                    dist_o       <= avg_c;
                    dist_valid_o <= 1'b1;
                    stable_cnt_o <= stable_cnt_next_c;
                    stable_o     <= (stable_cnt_next_c == CNT_W'(STABLE_CNT));
                end
            end else if (reject_c) begin
                miss_cnt <= miss_next_c;
                // Target lost: drop the window so averaging restarts from scratch
                if (miss_next_c == CNT_W'(MISS_LIMIT)) begin
                    lost_o       <= 1'b1;
                    stable_cnt_o <= '0;
                    stable_o     <= 1'b0;
                    wr_ptr       <= '0;
                    fill_cnt     <= '0;
                    sum          <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_distance_filter.sv
// Bench for distance_filter: directed scenarios plus randomized traffic, every
// cycle compared against a queue-based reference model of the filter rules.
module tb_distance_filter;

    localparam int DEPTH      = 4;
    localparam int MAX_DIST   = 100000;
    localparam int STABLE_TOL = 50;
    localparam int STABLE_CNT = 8;
    localparam int MISS_LIMIT = 3;

    logic        clk;
    logic        rst;
    logic        valid_i;
    logic [16:0] distance_i;
    logic        flush_i;
    logic [16:0] dist_o;
    logic        dist_valid_o;
    logic        stable_o;
    logic [7:0]  stable_cnt_o;
    logic        lost_o;

    distance_filter dut (
        .clk          (clk),
        .rst          (rst),
        .valid_i      (valid_i),
        .distance_i   (distance_i),
        .flush_i      (flush_i),
        .dist_o       (dist_o),
        .dist_valid_o (dist_valid_o),
        .stable_o     (stable_o),
        .stable_cnt_o (stable_cnt_o),
        .lost_o       (lost_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    int q[$];
    int exp_dist = 0;
    int exp_dv   = 0;
    int exp_cnt  = 0;
    int exp_lost = 0;
    int miss     = 0;
    int dv_seen  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_update(input int r, input int v, input int d, input int f);
        int s;
        int avg;
        int diff;
        bit was_full;
        exp_dv = 0;
        if (r != 0) begin
            q.delete();
            exp_dist = 0; exp_cnt = 0; exp_lost = 0; miss = 0;
        end else if (f != 0) begin
            q.delete();
            miss = 0; exp_cnt = 0;
        end else if (v != 0 && d > 0 && d <= MAX_DIST) begin
            miss = 0; exp_lost = 0;
            was_full = (q.size() == DEPTH);
            q.push_back(d);
            if (q.size() > DEPTH) void'(q.pop_front());
            if (q.size() == DEPTH) begin
                s = 0;
                foreach (q[i]) s += q[i];
                avg  = s / DEPTH;
                diff = (avg > exp_dist) ? avg - exp_dist : exp_dist - avg;
                if (!was_full)               exp_cnt = 0;
                else if (diff <= STABLE_TOL) exp_cnt = (exp_cnt < STABLE_CNT) ? exp_cnt + 1 : STABLE_CNT;
                else                         exp_cnt = 0;
                exp_dist = avg;
                exp_dv   = 1;
            end
        end else if (v != 0) begin
            if (miss < MISS_LIMIT) miss++;
            if (miss == MISS_LIMIT) begin
                exp_lost = 1; exp_cnt = 0;
                q.delete();
            end
        end
    endtask

    // One clock: drive on the falling edge, update model at the rising edge, compare just after
    task automatic step(input int r, input int v, input int d, input int f);
        @(negedge clk);
        rst        = (r != 0);
        valid_i    = (v != 0);
        distance_i = 17'(d);
        flush_i    = (f != 0);
        @(posedge clk);
        model_update(r, v, d, f);
        #1;
        if (dist_valid_o === 1'b1) dv_seen++;
        check("dist_valid", 32'(dist_valid_o), 32'(exp_dv));
        check("dist",       32'(dist_o),       32'(exp_dist));
        check("stable_cnt", 32'(stable_cnt_o), 32'(exp_cnt));
        check("stable",     32'(stable_o),     32'(exp_cnt == STABLE_CNT));
        check("lost",       32'(lost_o),       32'(exp_lost));
    endtask

    initial begin
        int base;
        int d;
        int v;
        int f;
        int r;
        rst = 1'b1; valid_i = 1'b0; distance_i = '0; flush_i = 1'b0;
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        check("rst_dist", 32'(dist_o), 32'd0);
        check("rst_lost", 32'(lost_o), 32'd0);

        // Four ramped accepts give a single first average
        dv_seen = 0;
        step(0, 1, 1000, 0);
        step(0, 1, 1004, 0);
        step(0, 1, 1008, 0);
        check("t2_no_early_out", 32'(dv_seen), 32'd0);
        step(0, 1, 1012, 0);
        check("t2_dv", 32'(dist_valid_o), 32'd1);
        check("t2_dist", 32'(dist_o), 32'd1006);
        check("t2_cnt", 32'(stable_cnt_o), 32'd0);

        // Constant input reaches and holds stability
        step(0, 0, 0, 1);
        dv_seen = 0;
        for (int i = 0; i < 12; i++) step(0, 1, 2000, 0);
        check("t3_outputs", 32'(dv_seen), 32'd9);
        check("t3_cnt", 32'(stable_cnt_o), 32'd8);
        check("t3_stable", 32'(stable_o), 32'd1);
        step(0, 1, 2000, 0);
        check("t3_sat", 32'(stable_cnt_o), 32'd8);

        // Step change breaks stability
        step(0, 1, 3000, 0);
        check("t4_dist", 32'(dist_o), 32'd2250);
        check("t4_cnt", 32'(stable_cnt_o), 32'd0);
        check("t4_stable", 32'(stable_o), 32'd0);

        // Three rejects lose the target; refill needs four accepts
        step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        check("t5_not_yet_lost", 32'(lost_o), 32'd0);
        step(0, 1, 100001, 0);
        check("t5_lost", 32'(lost_o), 32'd1);
        dv_seen = 0;
        step(0, 1, 500, 0);
        check("t5_lost_clear", 32'(lost_o), 32'd0);
        step(0, 1, 500, 0);
        step(0, 1, 500, 0);
        check("t5_no_early_out", 32'(dv_seen), 32'd0);
        step(0, 1, 500, 0);
        check("t5_dv", 32'(dist_valid_o), 32'd1);
        check("t5_dist", 32'(dist_o), 32'd500);

        // Flush wins over a coincident valid sample
        step(0, 1, 1500, 1);
        check("t6_no_out", 32'(dist_valid_o), 32'd0);
        check("t6_no_lost", 32'(lost_o), 32'd0);
        dv_seen = 0;
        for (int i = 0; i < 3; i++) step(0, 1, 1500, 0);
        check("t6_no_early_out", 32'(dv_seen), 32'd0);
        step(0, 1, 1500, 0);
        check("t6_dv", 32'(dist_valid_o), 32'd1);

        // Mid-stream reset empties the window
        step(1, 1, 1500, 0);
        step(1, 0, 0, 0);
        check("t1_dist", 32'(dist_o), 32'd0);
        check("t1_cnt", 32'(stable_cnt_o), 32'd0);
        dv_seen = 0;
        for (int i = 0; i < 3; i++) step(0, 1, 700, 0);
        check("t1_no_out", 32'(dv_seen), 32'd0);

        // Randomized traffic with jittered bases, bad echoes, flushes and resets
        base = 40000;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0) base = int'($urandom_range(1, MAX_DIST));
            v = ($urandom_range(0, 3) != 0) ? 1 : 0;
            case ($urandom_range(0, 19))
                0:       d = 0;
                1:       d = int'($urandom_range(MAX_DIST + 1, 131071));
                2:       d = int'($urandom_range(1, MAX_DIST));
                3:       d = MAX_DIST;
                default: d = base + int'($urandom_range(0, 60)) - 30;
            endcase
            if (d < 0) d = 0;
            f = ($urandom_range(0, 59) == 0) ? 1 : 0;
            r = ($urandom_range(0, 499) == 0) ? 1 : 0;
            step(r, v, d, f);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
